// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus port of the memory-mapped UART transmitter.
// One-cycle request strobe, registered read data.
interface uart_tx_mmio_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, byte FIFO,
// and a shift FSM that serialises bytes LSB-first at CLK_DIV clocks per bit.
module uart_tx_mmio #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_mmio_if.slave bus,
    output logic          uart_tx,
    output logic          tx_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       REG_TXDATA = 2'd0;
    localparam logic [1:0]       REG_STATUS = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    state_t           state;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    logic             wr_access;
    logic             rd_access;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic             clr_ovf;
    logic             full;
    logic             empty;
    logic             busy;
    logic             baud_end;
    logic [31:0]      status;
    logic             unused_bits;

    assign wr_access = bus.bus_req & bus.bus_we;
    assign rd_access = bus.bus_req & ~bus.bus_we;
    assign push      = wr_access & (bus.bus_addr[3:2] == REG_TXDATA);
    assign clr_ovf   = wr_access & (bus.bus_addr[3:2] == REG_STATUS) & bus.bus_wdata[3];

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    // Full is the pre-edge value, so a push into a full FIFO is dropped even
    // when the FSM pops on the same edge.
    assign push_ok  = push & ~full;
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign pop      = ~empty & ((state == S_IDLE) | ((state == S_STOP) & baud_end));
    assign busy     = (state != S_IDLE);
    assign tx_irq   = empty & ~busy;

    assign status = {23'd0, 5'(count), overflow, busy, empty, full};

    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8]};

    // NOTE: storage array carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.bus_wdata[7:0];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every block
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (push & full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg    <= fifo_mem[rd_ptr];
                        state    <= S_START;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        state    <= S_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_tx  <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit to avoid an idle gap.
                        if (pop) begin
                            shreg   <= fifo_mem[rd_ptr];
                            state   <= S_START;
                            uart_tx <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_rdata <= '0;
        end else if (rd_access) begin
            case (bus.bus_addr[3:2])
                REG_STATUS: bus.bus_rdata <= status;
                default:    bus.bus_rdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: frame-schedule reference model,
// register-access vector table, directed corner sequences and random traffic.
module tb_uart_tx_mmio;
    localparam int D     = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx;
    logic tx_irq;

    uart_tx_mmio_if bus_if ();

    uart_tx_mmio #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .uart_tx (uart_tx),
        .tx_irq  (tx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    int          rst_count = 0;
    logic [31:0] exp_rdata = '0;

    // Reference model: every accepted byte becomes a frame with a push edge
    // and a start edge; all observable state is derived from that schedule.
    int          fs[$];
    int          fp[$];
    logic [7:0]  fd[$];
    int          last_end = 0;
    bit          m_ovf = 1'b0;
    logic [7:0]  exp_rx[$];
    logic [7:0]  rx_q[$];

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int pending(int e);
        int c = 0;
        for (int k = 0; k < fs.size(); k++)
            if (fp[k] <= e && fs[k] > e) c++;
        return c;
    endfunction

    function automatic bit busy_at(int e);
        for (int k = 0; k < fs.size(); k++)
            if (fs[k] <= e && e < fs[k] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic line_at(int e);
        int         b;
        logic [7:0] v;
        for (int k = 0; k < fs.size(); k++) begin
            if (fs[k] <= e && e < fs[k] + FRAME) begin
                b = (e - fs[k]) / D;
                v = fd[k];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return v[b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_at(int e);
        int c = pending(e);
        return (32'(c) << 4) | (32'(m_ovf) << 3) | (32'(busy_at(e)) << 2)
             | (32'(c == 0) << 1) | 32'(c == DEPTH);
    endfunction

    function automatic void model_write(int n, logic [3:0] a, logic [31:0] d);
        int s;
        if (a[3:2] == 2'd0) begin
            if (pending(n - 1) >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                s = (last_end > n + 1) ? last_end : n + 1;
                fs.push_back(s);
                fp.push_back(n);
                fd.push_back(d[7:0]);
                exp_rx.push_back(d[7:0]);
                last_end = s + FRAME;
            end
        end else if (a[3:2] == 2'd1 && d[3]) begin
            m_ovf = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        fs.delete();
        fp.delete();
        fd.delete();
        last_end  = 0;
        m_ovf     = 1'b0;
        exp_rdata = '0;
    endfunction

    // Called at a falling edge: models the coming rising edge, then compares
    // all outputs at the next falling edge.
    task automatic tick();
        int n = edge_n + 1;
        if (rst_n && bus_if.bus_req) begin
            if (bus_if.bus_we) model_write(n, bus_if.bus_addr, bus_if.bus_wdata);
            else exp_rdata = (bus_if.bus_addr[3:2] == 2'd1) ? status_at(n - 1) : 32'd0;
        end
        @(posedge clk);
        edge_n = n;
        @(negedge clk);
        check("line", uart_tx, line_at(n));
        check("irq", tx_irq, (pending(n) == 0) && !busy_at(n));
        check("rdata", bus_if.bus_rdata, exp_rdata);
    endtask

    task automatic bus_write(logic [3:0] a, logic [31:0] d);
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        tick();
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
    endtask

    task automatic bus_read(logic [3:0] a, output logic [31:0] d);
        bus_if.bus_req  = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = a;
        tick();
        bus_if.bus_req  = 1'b0;
        d = bus_if.bus_rdata;
    endtask

    task automatic wait_idle();
        while (edge_n <= last_end) tick();
        tick();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        rst_count++;
        model_clear();
        #1;
        check("async_line", uart_tx, 1'b1);
        check("async_irq", tx_irq, 1'b1);
        check("async_rdata", bus_if.bus_rdata, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_rx(string name);
        check({name, "_count"}, rx_q.size(), exp_rx.size());
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
            check({name, "_byte"}, rx_q[i], exp_rx[i]);
    endtask

    // Serial receiver: samples mid-bit, drops frames cut short by a reset.
    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                int         rc;
                logic [7:0] b;
                logic       stop_bit;
                rc = rst_count;
                repeat (D / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (D) @(negedge clk);
                stop_bit = uart_tx;
                if (rc == rst_count && stop_bit === 1'b1) rx_q.push_back(b);
            end
        end
    end

    initial begin : main
        vec_t        vecs[12];
        logic [31:0] rd;
        logic [79:0] cap;
        logic [79:0] expv;
        logic [9:0]  f55;
        logic [19:0] fpair;
        int          start_edge;

        vecs[0]  = '{1'b0, 4'h0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 4'h4, 32'h0,        32'h2};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 4'hC, 32'h41,       32'h0};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,        32'h2};
        vecs[6]  = '{1'b1, 4'h8, 32'h42,       32'h0};
        vecs[7]  = '{1'b1, 4'hD, 32'h5A,       32'h0};
        vecs[8]  = '{1'b0, 4'h5, 32'h0,        32'h2};
        vecs[9]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{1'b0, 4'h4, 32'h0,        32'h2};
        vecs[11] = '{1'b0, 4'h3, 32'h0,        32'h0};

        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;

        // Power-on reset
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_line", uart_tx, 1'b1);
        check("reset_irq", tx_irq, 1'b1);
        check("reset_rdata", bus_if.bus_rdata, 32'd0);
        bus_read(4'h4, rd);
        check("reset_status", rd, 32'h2);

        // Single byte 0x55: line low one cycle after the write edge
        f55 = 10'b1010101010;
        bus_write(4'h0, 32'h55);
        check("pre_start_line", uart_tx, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            cap[i] = uart_tx;
            expv[i] = f55[i / D];
        end
        check("frame_55", cap[39:0], expv[39:0]);
        tick();
        tick();
        bus_read(4'h4, rd);
        check("status_after_single", rd, 32'h2);

        // Back-to-back 0x00, 0xFF: 80 contiguous cycles, no idle gap
        fpair = {10'b1111111110, 10'b1000000000};
        bus_write(4'h0, 32'h00);
        bus_write(4'h0, 32'hFF);
        cap[0] = uart_tx;
        for (int i = 1; i < 80; i++) begin
            tick();
            cap[i] = uart_tx;
        end
        for (int i = 0; i < 80; i++) expv[i] = fpair[i / D];
        check("frames_00_ff", cap, expv);
        wait_idle();

        // Fill and overflow
        rx_q.delete();
        exp_rx.delete();
        for (int i = 1; i <= 10; i++) bus_write(4'h0, 32'(i));
        bus_read(4'h4, rd);
        check("status_full_ovf", rd, 32'h8D);
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, rd);
        check("status_ovf_cleared", rd, 32'h85);
        wait_idle();
        check("fill_rx_count", rx_q.size(), 9);
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            check("fill_rx_byte", rx_q[i], 8'(i + 1));

        // Wrap-around: four bursts of five
        rx_q.delete();
        exp_rx.delete();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 5; j++) bus_write(4'h0, 32'(8'h10 + 5 * b + j));
            bus_read(4'h4, rd);
            check("burst_status", rd, 32'h44);
            wait_idle();
        end
        check("wrap_rx_count", rx_q.size(), 20);
        for (int i = 0; i < rx_q.size() && i < 20; i++)
            check("wrap_rx_byte", rx_q[i], 8'(8'h10 + i));

        // Reset during DATA bit 3 of 0xA5
        rx_q.delete();
        bus_write(4'h0, 32'hA5);
        start_edge = edge_n + 1;
        while (edge_n < start_edge + 4 * D + 1) tick();
        check("bit3_line", uart_tx, 1'b0);
        async_reset();
        bus_read(4'h4, rd);
        check("status_after_reset", rd, 32'h2);
        repeat (100) tick();
        check("no_frame_after_reset", rx_q.size(), 0);

        // Register decode table
        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rd);
                check("vec_rdata", rd, vecs[i].exp_rdata);
            end
            check("vec_irq", tx_irq, 1'b1);
        end

        // Random traffic against the schedule model
        rx_q.delete();
        exp_rx.delete();
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55)      bus_write({2'b00, 2'($urandom_range(0, 3))}, $urandom);
            else if (r < 62) bus_write({2'b01, 2'($urandom_range(0, 3))}, $urandom);
            else if (r < 70) bus_write(4'($urandom_range(8, 15)), $urandom);
            else if (r < 85) bus_read(4'($urandom_range(0, 15)), rd);
            else repeat ($urandom_range(1, 12)) tick();
        end
        wait_idle();
        check_rx("rand_rx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
